// File: rtl/bcd_borrow_pkg.sv
// Shared types and helpers for the two-digit BCD countdown counter.
package bcd_borrow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturate a load value so an out-of-range digit can never enter the registers.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] value, input logic [3:0] max_v);
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that strobes tick on the last count of each TICK_DIV window.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] count_q;
    logic            at_last;

    assign at_last = (count_q == CntLast);
    assign tick    = en && at_last;

    // Count only advances while enabled, so a paused window resumes where it left off.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= at_last ? '0 : count_q + CntW'(1);
        end
    end

endmodule

// File: rtl/bcd_borrow_counter.sv
// Two-digit BCD down-counter with run/pause control, optional wrap and a borrow pulse
// so a second instance can be chained through its ext_tick input.
module bcd_borrow_counter
    import bcd_borrow_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned TENS_MAX = 5,
    parameter bit          WRAP     = 1'b1,
    parameter bit          EXT_TICK = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [3:0] ld_ones,
    input  logic [3:0] ld_tens,
    input  logic       ext_tick,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       borrow,
    output logic       zero,
    output logic       busy
);

    localparam logic [3:0] TensMax = 4'(TENS_MAX);

    state_e     state_q, state_d;
    logic [3:0] ones_d, tens_d;
    logic       borrow_d;
    logic       presc_en, presc_clr, presc_tick, tick;

    // Higher-priority pause/load suppress the prescaler step so a coincident tick is held.
    assign presc_en  = (EXT_TICK == 1'b0) && (state_q == RUN) && !load && !pause;
    assign presc_clr = load || (state_q == IDLE) || (state_q == DONE);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (presc_en),
        .clr (presc_clr),
        .tick(presc_tick)
    );

    assign tick = (EXT_TICK != 1'b0) ? ext_tick : presc_tick;

    always_comb begin
        state_d  = state_q;
        ones_d   = ones;
        tens_d   = tens;
        borrow_d = 1'b0;

        if (load) begin
            ones_d  = bcd_clamp(ld_ones, BCD_MAX);
            tens_d  = bcd_clamp(ld_tens, TensMax);
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, PAUSE: begin
                    if (start) begin
                        state_d = (!WRAP && zero) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        // Reaching 00 keeps running; the wrap/stop choice waits for the next tick.
                        if (ones != 4'd0) begin
                            ones_d = ones - 4'd1;
                        end else if (tens != 4'd0) begin
                            ones_d = BCD_MAX;
                            tens_d = tens - 4'd1;
                        end else if (WRAP) begin
                            ones_d   = BCD_MAX;
                            tens_d   = TensMax;
                            borrow_d = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ones    <= 4'd0;
            tens    <= 4'd0;
            borrow  <= 1'b0;
            zero    <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            ones    <= ones_d;
            tens    <= tens_d;
            borrow  <= borrow_d;
            zero    <= (ones_d == 4'd0) && (tens_d == 4'd0);
            busy    <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_bcd_borrow_counter.sv
// Self-checking bench: reset/load, timing sequences, a vector table, a cascade pair and
// randomized ext-tick traffic compared against an arithmetic reference model.
module tb_bcd_borrow_counter;

    typedef struct packed {
        logic       load;
        logic [3:0] ldt;
        logic [3:0] ldo;
        logic       start;
        logic       pause;
        logic       ext;
    } drv_t;

    typedef struct {
        drv_t        d;
        logic [10:0] exp;
    } vec_t;

    typedef struct {
        int v;
        int st;
        bit b;
    } mdl_t;

    localparam int MI = 0, MR = 1, MP = 2, MD = 3;

    logic clk = 1'b0;
    logic rst;
    drv_t a_in, b_in, c_in, lo_in, hi_in;
    wire [10:0] a_q, b_q, c_q, lo_q, hi_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_borrow_counter #(.TICK_DIV(4), .TENS_MAX(5), .WRAP(1'b1), .EXT_TICK(1'b0)) u_a (
        .clk(clk), .rst(rst), .start(a_in.start), .pause(a_in.pause), .load(a_in.load),
        .ld_ones(a_in.ldo), .ld_tens(a_in.ldt), .ext_tick(a_in.ext),
        .ones(a_q[6:3]), .tens(a_q[10:7]), .borrow(a_q[2]), .zero(a_q[1]), .busy(a_q[0])
    );

    bcd_borrow_counter #(.TICK_DIV(4), .TENS_MAX(5), .WRAP(1'b0), .EXT_TICK(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(b_in.start), .pause(b_in.pause), .load(b_in.load),
        .ld_ones(b_in.ldo), .ld_tens(b_in.ldt), .ext_tick(b_in.ext),
        .ones(b_q[6:3]), .tens(b_q[10:7]), .borrow(b_q[2]), .zero(b_q[1]), .busy(b_q[0])
    );

    bcd_borrow_counter #(.TICK_DIV(4), .TENS_MAX(5), .WRAP(1'b1), .EXT_TICK(1'b1)) u_c (
        .clk(clk), .rst(rst), .start(c_in.start), .pause(c_in.pause), .load(c_in.load),
        .ld_ones(c_in.ldo), .ld_tens(c_in.ldt), .ext_tick(c_in.ext),
        .ones(c_q[6:3]), .tens(c_q[10:7]), .borrow(c_q[2]), .zero(c_q[1]), .busy(c_q[0])
    );

    bcd_borrow_counter #(.TICK_DIV(2), .TENS_MAX(5), .WRAP(1'b1), .EXT_TICK(1'b0)) u_lo (
        .clk(clk), .rst(rst), .start(lo_in.start), .pause(lo_in.pause), .load(lo_in.load),
        .ld_ones(lo_in.ldo), .ld_tens(lo_in.ldt), .ext_tick(lo_in.ext),
        .ones(lo_q[6:3]), .tens(lo_q[10:7]), .borrow(lo_q[2]), .zero(lo_q[1]), .busy(lo_q[0])
    );

    bcd_borrow_counter #(.TICK_DIV(4), .TENS_MAX(5), .WRAP(1'b1), .EXT_TICK(1'b1)) u_hi (
        .clk(clk), .rst(rst), .start(hi_in.start), .pause(hi_in.pause), .load(hi_in.load),
        .ld_ones(hi_in.ldo), .ld_tens(hi_in.ldt), .ext_tick(lo_q[2]),
        .ones(hi_q[6:3]), .tens(hi_q[10:7]), .borrow(hi_q[2]), .zero(hi_q[1]), .busy(hi_q[0])
    );

    function automatic logic [10:0] pk(int t, int o, bit b, bit z, bit bs);
        return {4'(t), 4'(o), b, z, bs};
    endfunction

    function automatic drv_t mkd(bit ld, int lt, int lo, bit st, bit pa, bit ex);
        drv_t d;
        d.load  = ld;
        d.ldt   = 4'(lt);
        d.ldo   = 4'(lo);
        d.start = st;
        d.pause = pa;
        d.ext   = ex;
        return d;
    endfunction

    function automatic vec_t row(drv_t d, logic [10:0] exp);
        vec_t r;
        r.d   = d;
        r.exp = exp;
        return r;
    endfunction

    // Reference model: count held as a plain integer 0..99, digits derived by / and %.
    function automatic mdl_t mstep(mdl_t m, drv_t d, int tmax, bit wrap);
        mdl_t n = m;
        n.b = 1'b0;
        if (d.load) begin
            n.v  = ((int'(d.ldt) > tmax) ? tmax : int'(d.ldt)) * 10
                 + ((int'(d.ldo) > 9) ? 9 : int'(d.ldo));
            n.st = MI;
        end else if (m.st == MR && d.pause) begin
            n.st = MP;
        end else if ((m.st == MI || m.st == MP) && d.start) begin
            n.st = (!wrap && m.v == 0) ? MD : MR;
        end else if (m.st == MR && d.ext) begin
            if (m.v > 0) begin
                n.v = m.v - 1;
            end else if (wrap) begin
                n.v = tmax * 10 + 9;
                n.b = 1'b1;
            end else begin
                n.st = MD;
            end
        end
        return n;
    endfunction

    function automatic logic [10:0] mexp(mdl_t m);
        return pk(m.v / 10, m.v % 10, m.b, m.v == 0, m.st == MR);
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got tens=%0d ones=%0d borrow=%b zero=%b busy=%b, want tens=%0d ones=%0d borrow=%b zero=%b busy=%b",
                     name, act[10:7], act[6:3], act[2], act[1], act[0],
                     exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    vec_t vecs[22];
    mdl_t m;
    drv_t d;

    initial begin
        vecs[0]  = row(mkd(1, 9, 12, 0, 0, 0), pk(5, 9, 0, 0, 0));
        vecs[1]  = row(mkd(1, 1, 0, 0, 0, 0),  pk(1, 0, 0, 0, 0));
        vecs[2]  = row(mkd(0, 0, 0, 1, 0, 0),  pk(1, 0, 0, 0, 1));
        vecs[3]  = row(mkd(0, 0, 0, 0, 0, 1),  pk(0, 9, 0, 0, 1));
        vecs[4]  = row(mkd(0, 0, 0, 0, 0, 1),  pk(0, 8, 0, 0, 1));
        vecs[5]  = row(mkd(0, 0, 0, 0, 1, 1),  pk(0, 8, 0, 0, 0));
        vecs[6]  = row(mkd(0, 0, 0, 0, 0, 1),  pk(0, 8, 0, 0, 0));
        vecs[7]  = row(mkd(0, 0, 0, 1, 0, 1),  pk(0, 8, 0, 0, 1));
        vecs[8]  = row(mkd(0, 0, 0, 0, 1, 0),  pk(0, 8, 0, 0, 0));
        vecs[9]  = row(mkd(0, 0, 0, 0, 1, 0),  pk(0, 8, 0, 0, 0));
        vecs[10] = row(mkd(0, 0, 0, 1, 0, 0),  pk(0, 8, 0, 0, 1));
        vecs[11] = row(mkd(1, 0, 1, 0, 0, 1),  pk(0, 1, 0, 0, 0));
        vecs[12] = row(mkd(0, 0, 0, 1, 0, 0),  pk(0, 1, 0, 0, 1));
        vecs[13] = row(mkd(0, 0, 0, 0, 0, 1),  pk(0, 0, 0, 1, 1));
        vecs[14] = row(mkd(1, 2, 3, 0, 0, 1),  pk(2, 3, 0, 0, 0));
        vecs[15] = row(mkd(1, 0, 0, 0, 0, 0),  pk(0, 0, 0, 1, 0));
        vecs[16] = row(mkd(0, 0, 0, 1, 0, 0),  pk(0, 0, 0, 1, 1));
        vecs[17] = row(mkd(0, 0, 0, 0, 0, 1),  pk(5, 9, 1, 0, 1));
        vecs[18] = row(mkd(0, 0, 0, 0, 0, 0),  pk(5, 9, 0, 0, 1));
        vecs[19] = row(mkd(0, 0, 0, 0, 0, 1),  pk(5, 8, 0, 0, 1));
        vecs[20] = row(mkd(0, 0, 0, 0, 0, 1),  pk(5, 7, 0, 0, 1));
        vecs[21] = row(mkd(1, 15, 15, 1, 0, 0), pk(5, 9, 0, 0, 0));

        a_in = '0; b_in = '0; c_in = '0; lo_in = '0; hi_in = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_a", a_q, pk(0, 0, 0, 1, 0));
        chk("reset_b", b_q, pk(0, 0, 0, 1, 0));
        chk("reset_c", c_q, pk(0, 0, 0, 1, 0));

        // Load then count 01 -> 00 -> wrap to 59 with a single borrow pulse.
        a_in = mkd(1, 3, 0, 0, 0, 0);
        @(negedge clk);
        a_in = '0;
        chk("load30", a_q, pk(3, 0, 0, 0, 0));
        a_in = mkd(1, 0, 1, 0, 0, 0);
        @(negedge clk);
        a_in = mkd(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        a_in = '0;
        for (int n = 0; n < 10; n++) begin
            int t, o;
            o = (n < 4) ? 1 : (n < 8) ? 0 : 9;
            t = (n < 8) ? 0 : 5;
            chk($sformatf("count_n%0d", n), a_q, pk(t, o, n == 8, (t == 0 && o == 0), 1'b1));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_midcount", a_q, pk(0, 0, 0, 1, 0));

        // Pause after two RUN cycles; the partial prescaler window survives the pause.
        a_in = mkd(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        a_in = mkd(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        a_in = '0;
        repeat (2) @(negedge clk);
        a_in.pause = 1'b1;
        @(negedge clk);
        a_in = '0;
        chk("pause_enter", a_q, pk(1, 0, 0, 0, 0));
        repeat (9) @(negedge clk);
        chk("pause_hold", a_q, pk(1, 0, 0, 0, 0));
        a_in.start = 1'b1;
        @(negedge clk);
        a_in = '0;
        chk("resume0", a_q, pk(1, 0, 0, 0, 1));
        @(negedge clk);
        chk("resume1", a_q, pk(1, 0, 0, 0, 1));
        @(negedge clk);
        chk("resume2", a_q, pk(0, 9, 0, 0, 1));

        // WRAP=0: stop in DONE on the tick after reaching 00.
        b_in = mkd(1, 0, 2, 0, 0, 0);
        @(negedge clk);
        b_in = mkd(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        b_in = '0;
        for (int n = 0; n < 14; n++) begin
            int o;
            o = (n < 4) ? 2 : (n < 8) ? 1 : 0;
            chk($sformatf("stop_n%0d", n), b_q, pk(0, o, 1'b0, o == 0, n < 12));
            @(negedge clk);
        end
        b_in.start = 1'b1;
        @(negedge clk);
        b_in = '0;
        chk("done_start", b_q, pk(0, 0, 0, 1, 0));
        b_in = mkd(1, 0, 5, 0, 0, 0);
        @(negedge clk);
        b_in = '0;
        chk("done_load05", b_q, pk(0, 5, 0, 0, 0));
        b_in.start = 1'b1;
        @(negedge clk);
        b_in = '0;
        chk("b_run05", b_q, pk(0, 5, 0, 0, 1));
        b_in = mkd(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        b_in = mkd(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        b_in = '0;
        chk("b_zero_start", b_q, pk(0, 0, 0, 1, 0));

        for (int i = 0; i < 22; i++) begin
            c_in = vecs[i].d;
            @(negedge clk);
            c_in = '0;
            chk($sformatf("vec%0d", i), c_q, vecs[i].exp);
        end

        // Randomized ext-tick traffic against the integer model.
        c_in = mkd(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        c_in = '0;
        m.v = 0; m.st = MI; m.b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            chk($sformatf("rand%0d", i), c_q, mexp(m));
            d = '0;
            d.load  = ($urandom_range(0, 19) == 0);
            d.ldt   = 4'($urandom_range(0, 15));
            d.ldo   = 4'($urandom_range(0, 15));
            d.start = ($urandom_range(0, 6) == 0);
            d.pause = ($urandom_range(0, 9) == 0);
            d.ext   = ($urandom_range(0, 1) == 1);
            c_in = d;
            m = mstep(m, d, 5, 1'b1);
            @(negedge clk);
        end
        chk("rand_final", c_q, mexp(m));
        c_in = '0;

        // Cascade: lower wraps 00 -> 59, upper sees the borrow one cycle later.
        lo_in = mkd(1, 0, 0, 0, 0, 0);
        hi_in = mkd(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        lo_in = mkd(0, 0, 0, 1, 0, 0);
        hi_in = mkd(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        lo_in = '0;
        hi_in = '0;
        chk("casc_lo0", lo_q, pk(0, 0, 0, 1, 1));
        chk("casc_hi0", hi_q, pk(1, 0, 0, 0, 1));
        @(negedge clk);
        chk("casc_lo1", lo_q, pk(0, 0, 0, 1, 1));
        @(negedge clk);
        chk("casc_lo2", lo_q, pk(5, 9, 1, 0, 1));
        chk("casc_hi2", hi_q, pk(1, 0, 0, 0, 1));
        @(negedge clk);
        chk("casc_lo3", lo_q, pk(5, 9, 0, 0, 1));
        chk("casc_hi3", hi_q, pk(0, 9, 0, 0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_borrow_counter.md
# bcd_borrow_counter

Two-digit BCD down-counter with prescaler, run/pause control and borrow cascade, for the D-Clock countdown/timer path. It generates the ones/tens digit pairs that the display digit-select mux chooses between. It emits a one-cycle borrow pulse on underflow so that a second instance, for the next-higher unit such as minutes, can be chained through its external-tick input.

## Interface

Parameters:
- TICK_DIV, 50_000_000: clk cycles per decrement when internal prescaler is used; must be ≥2
- TENS_MAX, 5: tens value reloaded on wrap; legal range 1..9
- WRAP, 1: 1 = underflow from 00 reloads {TENS_MAX,9} and continues; 0 = stop at 00 in DONE
- EXT_TICK, 0: 1 = decrement on ext_tick, prescaler unused; 0 = internal prescaler

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to begin/resume counting
- pause  in  1  single-cycle request to freeze counting
- load  in  1  load ld_tens/ld_ones into digits
- ld_ones  in  4  BCD ones load value
- ld_tens  in  4  BCD tens load value
- ext_tick  in  1  decrement strobe (cascade), used only when EXT_TICK=1
- ones  out  4  current ones digit (BCD)
- tens  out  4  current tens digit (BCD)
- borrow  out  1  one-cycle pulse on underflow
- zero  out  1  high while {tens,ones} == 00
- busy  out  1  high in RUN

## Operation

- States: IDLE, RUN, PAUSE, DONE.
- Reset values: ones=0, tens=0, borrow=0, zero=1, busy=0, state IDLE, prescaler=0.
- Priority each cycle: rst > load > pause > start > tick.
- load, any state:
  - digits ← ld values, clamped: ld_ones>9 → 9; ld_tens>TENS_MAX → TENS_MAX
  - state → IDLE; prescaler cleared; borrow forced 0
- IDLE/PAUSE + start → RUN. Exception: if WRAP=0 and zero=1, go → DONE.
- RUN + pause → PAUSE. Prescaler holds its value and is not cleared.
- pause in IDLE/PAUSE/DONE: ignored.
- start in DONE: ignored; only load exits DONE.
- Tick = (prescaler == TICK_DIV-1) when EXT_TICK=0, else ext_tick. Tick acts only in RUN.
- Decrement on tick:
  - ones>0: ones−1
  - ones==0, tens>0: ones=9, tens−1
  - 00 with WRAP=1: {TENS_MAX,9}, borrow=1
  - 00 with WRAP=0: hold 00, state → DONE, no borrow
- Reaching 00 by decrement does not by itself stop RUN. The stop/wrap decision is made on the next tick.
- Prescaler: counts 0..TICK_DIV−1 in RUN only, then wraps to 0. Held in PAUSE, cleared in IDLE/DONE.
- Digits never leave BCD range. Invalid load values are clamped, never passed through.

## Timing

- All outputs are registered.
- Digits and borrow update on the same edge that consumes the tick.
- Internal mode: first decrement is exactly TICK_DIV cycles after the edge that enters RUN. Subsequent decrements every TICK_DIV cycles; pause time is excluded.
- External mode: ext_tick high in cycle N → digits change at end of cycle N (visible in N+1). ext_tick held high for k cycles in RUN gives k decrements.
- borrow is high exactly one cycle per underflow. It is never asserted by load, start or reset.
- busy and zero change on the same edge as state/digits.
- Simultaneous pause and tick in RUN: pause wins, no decrement, prescaler holds at TICK_DIV−1. After resume, decrement occurs on the first RUN cycle.
- Simultaneous load and tick: load wins, no borrow.
- rst mid-count: all state returns to reset values on the next edge.

## Structure

- Package bcd_borrow_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}
  - BCD_MAX=9
  - function bcd_clamp(value, max)
- Sub-module tick_prescaler:
  - params TICK_DIV; width $clog2(TICK_DIV)
  - inputs clk, rst, en, clr; output tick
  - tick high when en=1 and count==TICK_DIV−1
- Top-level holds the FSM, digit registers and borrow register.
- Chaining:
  - lower instance's borrow drives the upper instance's ext_tick
  - upper instance built with EXT_TICK=1
  - both started together

## Test plan

- Reset/load (TICK_DIV=4): rst 1 cycle → ones=0, tens=0, zero=1, busy=0. Then load ld_tens=3, ld_ones=0 → digits 30, zero=0.
- Count/borrow (TICK_DIV=4, WRAP=1): load 01, start → 00 after 4 cycles, then 59 after 4 more with borrow high exactly 1 cycle, busy stays 1.
- Stop (WRAP=0): load 02, start → 01, 00, then DONE after third tick, no borrow. start in DONE ignored; load 05 → IDLE with digits 05.
- Pause (TICK_DIV=4): start, pause after 2 RUN cycles, hold 10 cycles, start → first decrement 2 cycles after resume.
- Clamp/priority: load ld_tens=9, ld_ones=12 with TENS_MAX=5 → 59. load and ext_tick together (EXT_TICK=1) in RUN → digits = load value, no borrow.
- Cascade (lower TICK_DIV=2 WRAP=1, upper EXT_TICK=1): lower 00, upper 10, both running → lower wraps to 59 and upper reads 09 on the same edge +1 cycle.
